// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and clear FSM encoding for regfile_2r1w
package regfile_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one registered read port with range check and write bypass
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  mem [DEPTH],
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  output logic              oor,
  output logic [WIDTH-1:0]  data_out,
  output logic              valid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic             addr_bad;
  logic [WIDTH-1:0] rd_data;

  assign addr_bad = ({1'b0, rd_addr} >= DEPTH_L);
  assign oor      = rd_en && addr_bad;

  // wr_ok is only ever true in IDLE, so bypass is naturally disabled while clearing
  always_comb begin
    rd_data = '0;
    if (!addr_bad) begin
      if (wr_ok && (wr_addr == rd_addr)) rd_data = data_in;
      else                               rd_data = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= rd_en;
      if (rd_en) data_out <= rd_data;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 1-write 2-read register file with hardware clear sequencer
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  data_out_a,
  output logic              valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              valid_b,
  input  logic              clr_start,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              wr_ok, wr_err, oor_a, oor_b;

  assign wr_ok  = wr_en && (state == ST_IDLE) && ({1'b0, wr_addr} < DEPTH_L);
  assign wr_err = wr_en && !wr_ok;

  // A write and clr_start in the same IDLE cycle both take effect; the walk erases it later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state <= ST_IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= wr_err | oor_a | oor_b;
      if (wr_ok) mem[wr_addr] <= data_in;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          mem[ptr] <= '0;
          if (ptr == LAST) begin
            state <= ST_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .mem      (mem),
    .wr_ok    (wr_ok),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .oor      (oor_a),
    .data_out (data_out_a),
    .valid    (valid_a)
  );

  regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .mem      (mem),
    .wr_ok    (wr_ok),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .oor      (oor_b),
    .data_out (data_out_b),
    .valid    (valid_b)
  );

endmodule
